// File: rtl/line_burst_adapter.sv
// line_burst_adapter: converts single-cycle cache line fill / writeback
// requests into multi-beat memory bursts of s_burst bits each.
// Optional feature macro: LINE_ADAPTER_BYPASS_EN -- completion is signalled
// combinationally in the final beat's cycle instead of one cycle later.
module line_burst_adapter #(
    parameter int s_offset = 5,
    parameter int s_burst  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   address_i,
    input  logic                          read_i,
    input  logic                          write_i,
    input  logic [8*(2**s_offset)-1:0]    line_i,
    output logic [8*(2**s_offset)-1:0]    line_o,
    output logic                          resp_o,
    output logic [31:0]                   address_o,
    output logic                          read_o,
    output logic                          write_o,
    output logic [s_burst-1:0]            burst_o,
    input  logic [s_burst-1:0]            burst_i,
    input  logic                          resp_i
);

    localparam int LINE_W = 8 * (2 ** s_offset);
    localparam int BEATS  = LINE_W / s_burst;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WBACK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic [31:0]          addr_r;
    logic [LINE_W-1:0]    wline_r;
    logic [LINE_W-1:0]    line_r;
    logic [s_burst-1:0]   burst_r;
    logic                 read_r;
    logic                 write_r;
    logic                 accept_wr_s;
    logic                 accept_rd_s;
    logic                 beat_s;
    logic                 last_beat_s;

    assign cnt_inc_s = cnt_r + CNT_ONE;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-cycle handshake strobes.
    always_comb begin
        state_next_s = state_r;
        accept_wr_s  = 1'b0;
        accept_rd_s  = 1'b0;
        beat_s       = 1'b0;
        last_beat_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // Writeback has priority when both requests arrive together.
                if (write_i) begin
                    accept_wr_s  = 1'b1;
                    state_next_s = WBACK;
                end else if (read_i) begin
                    accept_rd_s  = 1'b1;
                    state_next_s = FILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL, WBACK: begin
                if (resp_i) begin
                    beat_s = 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        last_beat_s = 1'b1;
`ifdef LINE_ADAPTER_BYPASS_EN
                        state_next_s = IDLE;
`else
                        state_next_s = DONE;
`endif
                    end else begin
                        state_next_s = state_r;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: request latching, beat counter, fill assembly, writeback beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= CNT_ZERO;
            addr_r  <= 32'd0;
            wline_r <= {LINE_W{1'b0}};
            line_r  <= {LINE_W{1'b0}};
            burst_r <= {s_burst{1'b0}};
            read_r  <= 1'b0;
            write_r <= 1'b0;
        end else begin
            read_r  <= (state_next_s == FILL);
            write_r <= (state_next_s == WBACK);
            if (accept_wr_s) begin
                wline_r <= line_i;
                addr_r  <= address_i & ADDR_MASK;
                cnt_r   <= CNT_ZERO;
                burst_r <= line_i[s_burst-1:0];
            end else if (accept_rd_s) begin
                addr_r  <= address_i & ADDR_MASK;
                cnt_r   <= CNT_ZERO;
            end else if (beat_s) begin
                cnt_r <= last_beat_s ? CNT_ZERO : cnt_inc_s;
                if (state_r == FILL) begin
                    line_r[int'(cnt_r)*s_burst +: s_burst] <= burst_i;
                end else if (!last_beat_s) begin
                    // Present the next writeback slot from the cycle after the accept.
                    burst_r <= wline_r[int'(cnt_inc_s)*s_burst +: s_burst];
                end
            end
        end
    end

    assign address_o = addr_r;
    assign read_o    = read_r;
    assign write_o   = write_r;
    assign burst_o   = burst_r;

`ifdef LINE_ADAPTER_BYPASS_EN
    logic [LINE_W-1:0] fill_view_s;

    // Forward the final incoming beat so the line is complete in the response cycle.
    always_comb begin
        fill_view_s = line_r;
        if (last_beat_s && (state_r == FILL)) begin
            fill_view_s[int'(CNT_LAST)*s_burst +: s_burst] = burst_i;
        end else begin
            fill_view_s = line_r;
        end
    end

    assign line_o = fill_view_s;
    assign resp_o = last_beat_s;
`else
    logic resp_r;

    // Completion pulse, high only for the single DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_r <= 1'b0;
        end else begin
            resp_r <= (state_next_s == DONE);
        end
    end

    assign line_o = line_r;
    assign resp_o = resp_r;
`endif

endmodule

// File: tb/tb_line_burst_adapter.sv
// Scoreboard bench for line_burst_adapter: the driver pushes expected
// completions and writeback beats into queues; a negedge monitor pops and
// compares whenever the DUT presents a response or an outgoing beat.
module tb_line_burst_adapter;

    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       address_i;
    logic              read_i;
    logic              write_i;
    logic [LINE_W-1:0] line_i;
    logic [LINE_W-1:0] line_o;
    logic              resp_o;
    logic [31:0]       address_o;
    logic              read_o;
    logic              write_o;
    logic [63:0]       burst_o;
    logic [63:0]       burst_i;
    logic              resp_i;

    typedef struct {
        logic [31:0]       addr;
        logic [LINE_W-1:0] line;
    } exp_t;

    exp_t        resp_q[$];
    logic [63:0] beat_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [LINE_W-1:0] last_fill;
    logic        resp_i_prev = 1'b0;

    always #5 clk = ~clk;

    line_burst_adapter #(.s_offset(5), .s_burst(64)) dut (
        .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i),
        .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
    );

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: exclusivity, writeback beats and completion responses.
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_exclusive", {255'd0, read_o & write_o}, 256'd0);
            if (write_o) begin
                check("beat_expected", {255'd0, beat_q.size() != 0}, 256'd1);
                if (beat_q.size() != 0) begin
                    check("burst_o", {192'd0, burst_o}, {192'd0, beat_q[0]});
                    if (resp_i) void'(beat_q.pop_front());
                end
            end
            if (resp_o) begin
                check("resp_expected", {255'd0, resp_q.size() != 0}, 256'd1);
                if (resp_q.size() != 0) begin
                    exp_t e;
                    e = resp_q.pop_front();
                    check("address_o", {224'd0, address_o}, {224'd0, e.addr});
                    check("line_o", line_o, e.line);
`ifdef LINE_ADAPTER_BYPASS_EN
                    check("resp_timing", {255'd0, resp_i}, 256'd1);
`else
                    check("resp_timing", {255'd0, resp_i_prev & ~resp_i}, 256'd1);
`endif
                end
            end
        end
        resp_i_prev <= resp_i;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && resp_q.size() != 0; i++) cycle();
        check("resp_drain", {224'd0, 32'(resp_q.size())}, 256'd0);
    endtask

    task automatic reset_and_check(input string tag);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_read_o"},    {255'd0, read_o},    256'd0);
        check({tag, "_write_o"},   {255'd0, write_o},   256'd0);
        check({tag, "_resp_o"},    {255'd0, resp_o},    256'd0);
        check({tag, "_address_o"}, {224'd0, address_o}, 256'd0);
        check({tag, "_burst_o"},   {192'd0, burst_o},   256'd0);
        check({tag, "_line_o"},    line_o,              256'd0);
        last_fill = 256'd0;
        cycle();
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] exp_addr,
                        input logic [63:0] b0, input logic [63:0] b1,
                        input logic [63:0] b2, input logic [63:0] b3,
                        input logic [LINE_W-1:0] exp_line);
        logic [63:0] beats [4];
        beats = '{b0, b1, b2, b3};
        resp_q.push_back('{exp_addr, exp_line});
        read_i = 1'b1;
        address_i = addr;
        cycle();
        read_i = 1'b0;
        address_i = 32'hDEAD_BEEF;
        check("fill_read_o", {255'd0, read_o}, 256'd1);
        check("fill_addr_held", {224'd0, address_o}, {224'd0, exp_addr});
        for (int b = 0; b < 4; b++) begin
            write_i = (b < 3);   // ignored while a fill is in flight
            resp_i = 1'b1;
            burst_i = beats[b];
            cycle();
        end
        write_i = 1'b0;
        resp_i = 1'b0;
        burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
        drain();
        last_fill = exp_line;
    endtask

    task automatic wback(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [LINE_W-1:0] line, input logic both,
                         input int g0, input int g1, input int g2, input int g3,
                         input logic [63:0] e0, input logic [63:0] e1,
                         input logic [63:0] e2, input logic [63:0] e3);
        int gaps [4];
        gaps = '{g0, g1, g2, g3};
        beat_q.push_back(e0);
        beat_q.push_back(e1);
        beat_q.push_back(e2);
        beat_q.push_back(e3);
        resp_q.push_back('{exp_addr, last_fill});
        write_i = 1'b1;
        read_i = both;
        address_i = addr;
        line_i = line;
        cycle();
        write_i = 1'b0;
        read_i = 1'b0;
        line_i = {4{64'h5A5A_5A5A_5A5A_5A5A}};
        check("wb_write_o", {255'd0, write_o}, 256'd1);
        check("wb_read_o_low", {255'd0, read_o}, 256'd0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gaps[b]; g++) cycle();
            resp_i = 1'b1;
            cycle();
            resp_i = 1'b0;
        end
        @(negedge clk);
        check("wb_write_o_dropped", {255'd0, write_o}, 256'd0);
        check("wb_beats_consumed", {224'd0, 32'(beat_q.size())}, 256'd0);
        cycle();
        drain();
    endtask

    // Watchdog against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; address_i = 32'd0; read_i = 1'b0; write_i = 1'b0;
        line_i = 256'd0; burst_i = 64'd0; resp_i = 1'b0;
        last_fill = 256'd0;
        cycle();
        reset_and_check("rst0");

        // Basic fill, byte address inside the line.
        fill(32'h0000_1234, 32'h0000_1220,
             64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
             {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Stray resp_i while idle must change nothing.
        for (int p = 0; p < 3; p++) begin
            resp_i = 1'b1;
            burst_i = 64'hFEED_0000_0000_0000 + 64'(p);
            cycle();
            resp_i = 1'b0;
            @(negedge clk);
            check("idle_line_o", line_o, last_fill);
            check("idle_address_o", {224'd0, address_o}, {224'd0, 32'h0000_1220});
            check("idle_strobes", {253'd0, read_o, write_o, resp_o}, 256'd0);
            cycle();
        end

        // Writeback with uneven response gaps; line_o keeps the fill data.
        wback(32'h0000_8ABC, 32'h0000_8AA0,
              {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
               64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD},
              1'b0, 0, 2, 0, 1,
              64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA);

        // read_i and write_i together: writeback wins.
        wback(32'hFFFF_FFFF, 32'hFFFF_FFE0,
              {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202,
               64'h0101_0101_0101_0101, 64'h0123_4567_89AB_CDEF},
              1'b1, 1, 0, 0, 0,
              64'h0123_4567_89AB_CDEF, 64'h0101_0101_0101_0101,
              64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303);

        // Reset after two fill beats aborts with no response.
        read_i = 1'b1;
        address_i = 32'h0000_0040;
        cycle();
        read_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            resp_i = 1'b1;
            burst_i = 64'h9999_9999_9999_9999;
            cycle();
        end
        resp_i = 1'b0;
        reset_and_check("rst_mid");

        // New fill after the abort restarts at beat 0.
        fill(32'h0000_0047, 32'h0000_0040,
             64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
             64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888,
             {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
              64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});

        repeat (3) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_burst_adapter.md
LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

Interface
REQ-001 Parameters SHALL be: s_offset, 5, log2 of line bytes (line = 8*2**s_offset bits); s_burst, 64, memory beat width in bits; beats = line/s_burst (default 4).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 address_i  in  32  cache-side request address, any byte within line.
REQ-005 read_i  in  1  cache requests line fill.
REQ-006 write_i  in  1  cache requests line writeback.
REQ-007 line_i  in  line  writeback line; byte k at bits [8k+7:8k].
REQ-008 line_o  out  line  assembled fill line, same byte ordering.
REQ-009 resp_o  out  1  one-cycle pulse: request complete.
REQ-010 address_o  out  32  memory address, line-aligned.
REQ-011 read_o / write_o  out  1 each  memory burst read / write request.
REQ-012 burst_o  out  s_burst  outgoing beat.  burst_i  in  s_burst  incoming beat.
REQ-013 resp_i  in  1  memory beat accepted (write) or beat valid (read).

Function
REQ-014 FSM states SHALL be IDLE, FILL, WBACK, DONE.
REQ-015 IDLE: on write_i SHALL latch line_i and address_i, clear beat counter, enter WBACK; else on read_i latch address_i, enter FILL; write_i wins if both asserted.
REQ-016 address_o SHALL equal latched address with low s_offset bits zeroed, held constant from acceptance through DONE.
REQ-017 FILL: read_o high; each cycle with resp_i SHALL store burst_i into line_o beat slot[cnt] (bits [s_burst*cnt +: s_burst]) and increment cnt.
REQ-018 WBACK: write_o high; burst_o SHALL equal latched line slot[cnt]; each resp_i increments cnt, burst_o advancing the following cycle.
REQ-019 On resp_i with cnt = beats-1, SHALL drop read_o/write_o the next cycle, wrap cnt to 0, enter DONE.
REQ-020 DONE: resp_o high exactly one cycle, then IDLE; read_i/write_i ignored during DONE.
REQ-021 read_i/write_i changes after acceptance SHALL be ignored until IDLE.
REQ-022 resp_i while IDLE or DONE SHALL be ignored (no state, counter, or line_o change).
REQ-023 line_o SHALL hold its last fill value until next FILL overwrites beats; unchanged by WBACK.
REQ-024 read_o and write_o SHALL never be high simultaneously.

Reset
REQ-025 rst SHALL force IDLE, cnt=0, read_o=write_o=resp_o=0, address_o=0, burst_o=0, line_o=0.
REQ-026 rst mid-FILL/WBACK SHALL abort the burst with no resp_o; next request restarts from beat 0.

Configuration
REQ-027 Macro LINE_ADAPTER_BYPASS_EN: when defined, the final beat's resp_i cycle SHALL assert resp_o combinationally, with line_o presenting burst_i in the top slot that same cycle, skipping DONE (IDLE next cycle); when undefined, REQ-019/020 timing applies (resp_o one cycle after final beat).

Verification
REQ-028 Fill: read_i, address_i=0x0000_1234, beats 0x11..11,0x22..22,0x33..33,0x44..44 on consecutive resp_i -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, one resp_o pulse.
REQ-029 Writeback: write_i, line_i=0xA..A(beat3)..0xD..D(beat0), resp_i with gaps 0,2,0,1 -> burst_o sequence 0xD..,0xC..,0xB..,0xA.., each held until its resp_i; write_o low after 4th.
REQ-030 read_i and write_i both high in IDLE -> WBACK taken, read_o stays 0.
REQ-031 rst asserted after 2 fill beats -> outputs zero next cycle, no resp_o; new fill completes normally from beat 0.
REQ-032 resp_i pulses in IDLE -> no change to line_o, cnt, or outputs.
REQ-033 With LINE_ADAPTER_BYPASS_EN: fill resp_o coincides with 4th resp_i; without: one cycle later.
